// File: rtl/ula_arb_pkg.sv
// Shared types and widths for the ULA arbiter and its bench.
package ula_arb_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned LAT_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_DIV  = 4'h3,
    OP_SHL  = 4'h4,
    OP_SHR  = 4'h5,
    OP_ROL  = 4'h6,
    OP_ROR  = 4'h7,
    OP_AND  = 4'h8,
    OP_OR   = 4'h9,
    OP_XOR  = 4'hA,
    OP_NOR  = 4'hB,
    OP_NAND = 4'hC,
    OP_XNOR = 4'hD,
    OP_GT   = 4'hE,
    OP_EQ   = 4'hF
  } op_t;

  // One ULA operation as presented by a requester.
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [SEL_W-1:0]  sel;
  } ula_op_t;

endpackage

// File: rtl/ula_rr_pick.sv
// Round-robin winner selection: first valid requester after 'last', wrapping.
module ula_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  last,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  logic [ID_W-1:0] cand;

  // Scan last+1 .. last+N_REQ modulo N_REQ and keep the first hit.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((32'(last) + k) % N_REQ);
      if (!any && valid[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one ULA among N_REQ requesters.
// Optional build macro ULA_ARBITER_STATS_EN adds grant_cnt / stall_cnt.
module ula_arbiter import ula_arb_pkg::*; #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ULA_LAT = 1,
  parameter int unsigned ID_W    = $clog2(N_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*DATA_W-1:0]   req_a,
  input  logic [N_REQ*DATA_W-1:0]   req_b,
  input  logic [N_REQ*SEL_W-1:0]    req_sel,
  output logic [DATA_W-1:0]         ula_a,
  output logic [DATA_W-1:0]         ula_b,
  output logic [SEL_W-1:0]          ula_sel,
  input  logic [DATA_W-1:0]         ula_out,
  input  logic                      ula_carry,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_out,
  output logic                      rsp_carry,
  output logic                      busy
`ifdef ULA_ARBITER_STATS_EN
  ,
  output logic [N_REQ*CNT_W-1:0]    grant_cnt,
  output logic [CNT_W-1:0]          stall_cnt
`endif
);

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_EXEC = 2'(EXEC);
  localparam logic [1:0] S_RESP = 2'(RESP);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [N_REQ-1:0] pick_grant;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;
  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  id_q;
  logic [LAT_W-1:0] lat_cnt;
  logic             grant_fire;
  logic             capture;
  logic             rsp_fire;
  ula_op_t          pick_op;

  ula_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .valid (req_valid),
    .last  (last_grant),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Select the winning requester's operands.
  always_comb begin
    pick_op = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_grant[i]) begin
        pick_op.a   = req_a[i*DATA_W +: DATA_W];
        pick_op.b   = req_b[i*DATA_W +: DATA_W];
        pick_op.sel = req_sel[i*SEL_W +: SEL_W];
      end
    end
  end

  // Next-state and handshake decode; req_ready is held low while in reset.
  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    grant_fire = 1'b0;
    capture    = 1'b0;
    rsp_fire   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_any && reset) begin
          req_ready  = pick_grant;
          grant_fire = 1'b1;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        if (lat_cnt == LAT_W'(1)) begin
          capture = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_fire = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath: issue to the ULA, count latency, capture and hold the response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ula_a      <= '0;
      ula_b      <= '0;
      ula_sel    <= '0;
      id_q       <= '0;
      last_grant <= ID_W'(N_REQ - 1);
      lat_cnt    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_out    <= '0;
      rsp_carry  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy <= (state_d != S_IDLE);
      if (grant_fire) begin
        ula_a      <= pick_op.a;
        ula_b      <= pick_op.b;
        ula_sel    <= pick_op.sel;
        id_q       <= pick_idx;
        last_grant <= pick_idx;
        lat_cnt    <= LAT_W'(ULA_LAT);
      end else if (state_q == S_EXEC) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
      end
      if (capture) begin
        rsp_out   <= ula_out;
        rsp_carry <= ula_carry;
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end else if (rsp_fire) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ULA_ARBITER_STATS_EN
  // Saturating per-requester grant counters and busy-stall counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && req_ready[i] && (grant_cnt[i*CNT_W +: CNT_W] != '1))
          grant_cnt[i*CNT_W +: CNT_W] <= grant_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
      if ((|req_valid) && (state_q != S_IDLE) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`else
  // Statistics counters are not built.
`endif

endmodule
